// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with 3-sample majority voting,
// per-character parity/frame error flags, break detection and an FWFT FIFO.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   bit_in                raw asynchronous RX line (idles high)
//   byte_out_*            FIFO head: data, frame_err, parity_err, valid; ready pops
//   fifo_count            occupied FIFO entries
//   overflow              1-cycle pulse when a completed character is dropped
//   break_det             1-cycle pulse when a break condition is recognised
module uart_rx_cfg #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          bit_in,
    output logic [DATA_BITS-1:0]          byte_out_data,
    output logic                          byte_out_frame_err,
    output logic                          byte_out_parity_err,
    output logic                          byte_out_valid,
    input  logic                          byte_out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          break_det
);
    localparam int TPB = CLK_FREQ_HZ / BAUD_RATE;
    localparam int MID = TPB / 2;
    localparam int TW  = $clog2(TPB);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int EW  = DATA_BITS + 2;
    localparam logic [TW-1:0] T_LO  = TW'(MID - 1);
    localparam logic [TW-1:0] T_MID = TW'(MID);
    localparam logic [TW-1:0] T_HI  = TW'(MID + 1);
    localparam logic [TW-1:0] T_END = TW'(TPB - 1);
    localparam logic [3:0] LAST_D = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);
    localparam logic ODD = 1'(PARITY == 1);

    if (TPB < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SYNC_STAGES < 2) begin : g_bad_cfg
        $error("uart_rx_cfg: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    state_e                 state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [3:0]             bit_q, bit_d;
    logic [1:0]             smp_q, smp_d;
    logic [DATA_BITS-1:0]   sh_q, sh_d;
    logic                   par_q, par_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   mid_hit, end_hit, vote, wr, brk;
    logic [EW-1:0]          wr_ent;

    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wptr_q, rptr_q;
    logic [CW-1:0]          count_q, count_d;
    logic                   full, pop, push;

    assign rxs     = sync_q[SYNC_STAGES-1];
    assign mid_hit = tick_q == T_HI;
    assign end_hit = tick_q == T_END;
    // Majority of the samples taken at MID-1, MID and the live one at MID+1.
    assign vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
    // A non-last stop bit low is folded into ferr_q; the live vote covers the last one.
    assign wr_ent  = {ferr_q | ~vote, perr_q, sh_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            smp_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bit_in};
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            smp_q   <= smp_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = end_hit ? '0 : tick_q + TW'(1);
        bit_d   = bit_q;
        smp_d   = {tick_q == T_MID ? rxs : smp_q[1], tick_q == T_LO ? rxs : smp_q[0]};
        sh_d    = sh_q;
        par_d   = par_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        wr      = 1'b0;
        brk     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tick_d  = '0;
                bit_d   = '0;
                par_d   = 1'b0;
                perr_d  = 1'b0;
                ferr_d  = 1'b0;
                state_d = rxs ? S_IDLE : S_START;
            end
            S_START: begin
                if (mid_hit && vote) begin
                    state_d = S_IDLE;
                    tick_d  = '0;
                end else if (end_hit) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (mid_hit) sh_d = {vote, sh_q[DATA_BITS-1:1]};
                if (end_hit) begin
                    bit_d   = (bit_q == LAST_D) ? 4'd0 : bit_q + 4'd1;
                    state_d = (bit_q != LAST_D) ? S_DATA : (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (mid_hit) begin
                    par_d  = vote;
                    perr_d = ^sh_q ^ vote ^ ODD;
                end
                if (end_hit) state_d = S_STOP;
            end
            S_STOP: begin
                if (mid_hit) begin
                    // Break: all-zero data, zero parity bit and a low first stop bit.
                    if (!vote && bit_q == 4'd0 && sh_q == '0 && !par_q) begin
                        wr      = 1'b1;
                        brk     = 1'b1;
                        state_d = S_BRK_WAIT;
                        tick_d  = '0;
                    end else if (bit_q == LAST_S) begin
                        wr      = 1'b1;
                        state_d = S_IDLE;
                        tick_d  = '0;
                    end else begin
                        ferr_d  = ferr_q | ~vote;
                    end
                end
                if (end_hit) bit_d = bit_q + 4'd1;
            end
            S_BRK_WAIT: begin
                tick_d  = '0;
                state_d = rxs ? S_IDLE : S_BRK_WAIT;
            end
            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
            end
        endcase
    end

    assign byte_out_valid = count_q != '0;
    assign full     = count_q == CW'(FIFO_DEPTH);
    assign pop      = byte_out_valid & byte_out_ready;
    // When full, a same-cycle pop frees the slot the write needs.
    assign push     = wr & (~full | pop);
    assign overflow = wr & full & ~pop;
    assign break_det = brk;
    assign count_d  = count_q + CW'(push) - CW'(pop);
    assign fifo_count = count_q;
    // Head is gated so the outputs read zero whenever the FIFO is empty.
    assign {byte_out_frame_err, byte_out_parity_err, byte_out_data} =
        byte_out_valid ? mem_q[rptr_q] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= push ? wptr_q + AW'(1) : wptr_q;
            rptr_q  <= pop ? rptr_q + AW'(1) : rptr_q;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_ent;
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed self-checking bench for uart_rx_cfg (8N1 and 8O1 instances).
module tb_uart_rx_cfg;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       bit_n = 1'b1, bit_o = 1'b1, ready_n = 1'b0, ready_o = 1'b0;
    logic [7:0] data_n, data_o;
    logic       ferr_n, perr_n, valid_n, ovf_n, brk_n;
    logic       ferr_o, perr_o, valid_o, ovf_o, brk_o;
    logic [4:0] cnt_n, cnt_o;
    int tests = 0, fails = 0, ovf_cnt = 0, brk_cnt = 0, ovf0 = 0, brk0 = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_FREQ_HZ(100_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16), .SYNC_STAGES(2)) u_n (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_n),
        .byte_out_data(data_n), .byte_out_frame_err(ferr_n), .byte_out_parity_err(perr_n),
        .byte_out_valid(valid_n), .byte_out_ready(ready_n), .fifo_count(cnt_n),
        .overflow(ovf_n), .break_det(brk_n));

    uart_rx_cfg #(.CLK_FREQ_HZ(100_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                  .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16), .SYNC_STAGES(2)) u_o (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_o),
        .byte_out_data(data_o), .byte_out_frame_err(ferr_o), .byte_out_parity_err(perr_o),
        .byte_out_valid(valid_o), .byte_out_ready(ready_o), .fifo_count(cnt_o),
        .overflow(ovf_o), .break_det(brk_o));

    always @(negedge clk) begin
        if (ovf_n) ovf_cnt++;
        if (brk_n) brk_cnt++;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put(input bit sel, input logic v);
        if (sel) bit_o = v;
        else bit_n = v;
        repeat (100) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input bit has_par, input logic pb);
        @(posedge clk);
        #1;
        put(sel, 1'b0);
        for (int i = 0; i < 8; i++) put(sel, d[i]);
        if (has_par) put(sel, pb);
        put(sel, 1'b1);
    endtask

    task automatic pop(input bit sel, input string tag, input logic [7:0] d, input logic fe, input logic pe);
        @(negedge clk);
        check({tag, "_valid"}, sel ? valid_o : valid_n, 1);
        check({tag, "_data"}, sel ? data_o : data_n, d);
        check({tag, "_ferr"}, sel ? ferr_o : ferr_n, fe);
        check({tag, "_perr"}, sel ? perr_o : perr_n, pe);
        if (sel) ready_o = 1'b1;
        else ready_n = 1'b1;
        @(posedge clk);
        #1;
        ready_o = 1'b0;
        ready_n = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", valid_n, 0);
        check("rst_count", cnt_n, 0);
        check("rst_ovf", ovf_n, 0);
        check("rst_brk", brk_n, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // 8N1 0xA5 with ready held high: write at stop tick MID+1, visible one cycle later
        ready_n = 1'b1;
        fork
            send(0, 8'hA5, 0, 0);
            begin
                @(posedge clk);
                #1;
                repeat (954) @(posedge clk);
                @(negedge clk) check("t1_latency", valid_n, 0);
                @(negedge clk);
                check("t1_valid", valid_n, 1);
                check("t1_data", data_n, 8'hA5);
                check("t1_ferr", ferr_n, 0);
                check("t1_perr", perr_n, 0);
                check("t1_cnt1", cnt_n, 1);
                @(negedge clk);
                check("t1_cnt0", cnt_n, 0);
                check("t1_empty", valid_n, 0);
            end
        join
        ready_n = 1'b0;

        // 8O1: 0x3C has four ones, so the odd parity bit is 1
        send(1, 8'h3C, 1, 1'b1);
        send(1, 8'h3C, 1, 1'b0);
        check("t2_cnt", cnt_o, 2);
        pop(1, "t2_good", 8'h3C, 0, 0);
        pop(1, "t2_bad", 8'h3C, 0, 1);

        // 30-cycle glitch must not produce an entry
        @(posedge clk);
        #1 bit_n = 1'b0;
        repeat (30) @(posedge clk);
        #1 bit_n = 1'b1;
        repeat (300) @(posedge clk);
        check("t3_glitch_cnt", cnt_n, 0);
        // one-cycle low spike in the middle of data bit 3 of 0xFF
        fork
            send(0, 8'hFF, 0, 0);
            begin
                @(posedge clk);
                #1;
                repeat (450) @(posedge clk);
                #1 bit_n = 1'b0;
                @(posedge clk);
                #1 bit_n = 1'b1;
            end
        join
        check("t3_cnt", cnt_n, 1);
        pop(0, "t3_ff", 8'hFF, 0, 0);

        // fill, overflow on the 17th, then write+pop on the same cycle while full
        ovf0 = ovf_cnt;
        for (int i = 0; i < 16; i++) send(0, 8'(i), 0, 0);
        check("t4_full_cnt", cnt_n, 16);
        check("t4_no_ovf", ovf_cnt - ovf0, 0);
        send(0, 8'h10, 0, 0);
        check("t4_ovf_pulse", ovf_cnt - ovf0, 1);
        check("t4_cnt_sat", cnt_n, 16);
        fork
            send(0, 8'h11, 0, 0);
            begin
                @(posedge clk);
                #1;
                repeat (954) @(posedge clk);
                #1 ready_n = 1'b1;
                @(negedge clk);
                check("t4_sim_ovf", ovf_n, 0);
                check("t4_sim_head", data_n, 8'h00);
                @(posedge clk);
                #1 ready_n = 1'b0;
            end
        join
        check("t4_sim_cnt", cnt_n, 16);
        check("t4_sim_ovf_total", ovf_cnt - ovf0, 1);
        for (int i = 1; i < 16; i++) pop(0, "t4_drain", 8'(i), 0, 0);
        pop(0, "t4_last", 8'h11, 0, 0);
        check("t4_empty", cnt_n, 0);

        // break: line low for 30 bit times
        brk0 = brk_cnt;
        @(posedge clk);
        #1 bit_n = 1'b0;
        repeat (3000) @(posedge clk);
        #1;
        check("t5_cnt", cnt_n, 1);
        check("t5_brk_pulse", brk_cnt - brk0, 1);
        bit_n = 1'b1;
        repeat (200) @(posedge clk);
        check("t5_cnt_after", cnt_n, 1);
        pop(0, "t5_brk", 8'h00, 1, 0);
        send(0, 8'h55, 0, 0);
        check("t5_next_cnt", cnt_n, 1);
        check("t5_brk_once", brk_cnt - brk0, 1);
        @(negedge clk);
        check("t5_next_data", data_n, 8'h55);
        check("t5_next_ferr", ferr_n, 0);

        // reset during data bit 4; the pending 0x55 entry must also vanish
        fork
            send(0, 8'h81, 0, 0);
            begin
                @(posedge clk);
                #1;
                repeat (550) @(posedge clk);
                #1 rst_n = 1'b0;
                @(negedge clk);
                check("t6_rst_cnt", cnt_n, 0);
                check("t6_rst_valid", valid_n, 0);
                check("t6_rst_data", data_n, 0);
                check("t6_rst_ferr", ferr_n, 0);
            end
        join
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        check("t6_discard", cnt_n, 0);
        send(0, 8'h81, 0, 0);
        check("t6_cnt", cnt_n, 1);
        pop(0, "t6_81", 8'h81, 0, 0);
        check("t6_empty", cnt_n, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
